// File: rtl/ioread_mux.sv
// Multi-channel IO read mux: per-channel synchronizer and debouncer, one-hot
// select read port with sticky change flags and an illegal-select pulse.
module ioread_mux #(
    parameter int DW      = 16,
    parameter int NCH     = 4,
    parameter int DEB_CYC = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ior,
    input  logic [NCH-1:0]    chsel,
    input  logic [NCH*DW-1:0] io_in,
    output logic [DW-1:0]     ioread_data,
    output logic              rd_valid,
    output logic              sel_err,
    output logic [NCH-1:0]    chg
);

    localparam int CW = (DEB_CYC > 0) ? $clog2(DEB_CYC + 1) : 1;

    logic [DW-1:0]  s1       [NCH];
    logic [DW-1:0]  s2       [NCH];
    logic [DW-1:0]  s2_d     [NCH];
    logic [DW-1:0]  stab     [NCH];
    logic [DW-1:0]  stab_nxt [NCH];
    logic [CW-1:0]  cnt      [NCH];
    logic [CW-1:0]  cnt_nxt  [NCH];
    logic [NCH-1:0] deb_set;
    logic [NCH-1:0] rd_clr;
    logic [NCH-1:0] chg_nxt;
    logic           sel_onehot;
    logic           rd_ok;
    logic           rd_bad;
    logic [DW-1:0]  rd_mux;

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin : debounce
        for (int c = 0; c < NCH; c++) begin
            stab_nxt[c] = stab[c];
            cnt_nxt[c]  = '0;
            deb_set[c]  = 1'b0;
            if (DEB_CYC == 0) begin
                // Bypass: stab follows the value s2 takes at this edge, so a
                // step reaches stab one edge after it enters s1.
                stab_nxt[c] = s1[c];
                deb_set[c]  = (s1[c] != stab[c]);
            end else if ((s2[c] != stab[c]) && (s2[c] == s2_d[c])) begin
                if (int'(cnt[c]) + 1 == DEB_CYC) begin
                    stab_nxt[c] = s2[c];
                    deb_set[c]  = 1'b1;
                end else begin
                    cnt_nxt[c] = cnt[c] + CW'(1);
                end
            end
        end
    end

    always_comb begin : read_path
        sel_onehot = (chsel != '0) && ((chsel & (chsel - NCH'(1))) == '0);
        rd_ok      = ior && sel_onehot;
        rd_bad     = ior && !sel_onehot;
        rd_mux     = '0;
        for (int c = 0; c < NCH; c++) begin
            if (chsel[c]) rd_mux = rd_mux | stab[c];
        end
        rd_clr  = rd_ok ? chsel : '0;
        // NOTE: set is OR-ed after clear so a same-edge debounce update is never lost.
        chg_nxt = (chg & ~rd_clr) | deb_set;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: these arrays are plain flops, not RAM, so resetting them in a loop is fine.
            for (int c = 0; c < NCH; c++) begin
                s1[c]   <= '0;
                s2[c]   <= '0;
                s2_d[c] <= '0;
                stab[c] <= '0;
                cnt[c]  <= '0;
            end
            ioread_data <= '0;
            rd_valid    <= 1'b0;
            sel_err     <= 1'b0;
            chg         <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                s1[c]   <= io_in[c*DW +: DW];
                s2[c]   <= s1[c];
                s2_d[c] <= s2[c];
                stab[c] <= stab_nxt[c];
                cnt[c]  <= cnt_nxt[c];
            end
            if (rd_ok) ioread_data <= rd_mux;
            rd_valid <= rd_ok;
            sel_err  <= rd_bad;
            chg      <= chg_nxt;
        end
    end

endmodule

// File: tb/tb_ioread_mux.sv
// Bench for ioread_mux: a debounced instance and a bypass instance share stimulus
// and are compared every cycle against a sample-history model.
module tb_ioread_mux;

    localparam int DW  = 16;
    localparam int NCH = 4;
    localparam int NM  = 2;

    logic              clk   = 1'b0;
    logic              reset = 1'b0;
    logic              ior   = 1'b0;
    logic [NCH-1:0]    chsel = '0;
    logic [NCH*DW-1:0] io_in = '0;

    logic [DW-1:0]  data_a, data_b;
    logic           rv_a, rv_b, se_a, se_b;
    logic [NCH-1:0] chg_a, chg_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ioread_mux #(.DW(DW), .NCH(NCH), .DEB_CYC(4)) dut (
        .clk(clk), .reset(reset), .ior(ior), .chsel(chsel), .io_in(io_in),
        .ioread_data(data_a), .rd_valid(rv_a), .sel_err(se_a), .chg(chg_a)
    );

    ioread_mux #(.DW(DW), .NCH(NCH), .DEB_CYC(0)) dut_byp (
        .clk(clk), .reset(reset), .ior(ior), .chsel(chsel), .io_in(io_in),
        .ioread_data(data_b), .rd_valid(rv_b), .sel_err(se_b), .chg(chg_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: hist[c][j] is the io_in value sampled j edges ago (0 = this edge).
    // A value v is adopted when the last DEB+1 samples that have left the
    // synchronizer all equal v; in bypass the newest synchronized sample wins.
    logic [DW-1:0]  hist   [NCH][8];
    logic [DW-1:0]  m_stab [NM][NCH];
    logic [NCH-1:0] m_chg  [NM];
    logic [DW-1:0]  m_data [NM];
    logic           m_rv, m_se;
    logic           m_live = 1'b0;

    function automatic int deb_of(input int m);
        return (m == 0) ? 4 : 0;
    endfunction

    task automatic model_step();
        int             k, d;
        logic [DW-1:0]  v;
        logic           ok;
        logic [NCH-1:0] clr, set;
        if (!reset) begin
            for (int c = 0; c < NCH; c++)
                for (int j = 0; j < 8; j++) hist[c][j] = '0;
            for (int m = 0; m < NM; m++) begin
                for (int c = 0; c < NCH; c++) m_stab[m][c] = '0;
                m_chg[m]  = '0;
                m_data[m] = '0;
            end
            m_rv   = 1'b0;
            m_se   = 1'b0;
            m_live = 1'b1;
            return;
        end
        k = 0;
        for (int c = 0; c < NCH; c++) if (chsel[c]) k = c;
        m_rv = ior && ($countones(chsel) == 1);
        m_se = ior && ($countones(chsel) != 1);
        clr  = m_rv ? chsel : '0;
        for (int m = 0; m < NM; m++) if (m_rv) m_data[m] = m_stab[m][k];
        for (int c = 0; c < NCH; c++) begin
            for (int j = 7; j > 0; j--) hist[c][j] = hist[c][j-1];
            hist[c][0] = io_in[c*DW +: DW];
        end
        for (int m = 0; m < NM; m++) begin
            set = '0;
            d   = deb_of(m);
            for (int c = 0; c < NCH; c++) begin
                ok = 1'b1;
                if (d == 0) begin
                    v = hist[c][1];
                end else begin
                    v = hist[c][2];
                    for (int j = 2; j <= 2 + d; j++) if (hist[c][j] != v) ok = 1'b0;
                end
                if (ok && (v != m_stab[m][c])) begin
                    m_stab[m][c] = v;
                    set[c] = 1'b1;
                end
            end
            m_chg[m] = (m_chg[m] & ~clr) | set;
        end
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        if (m_live) begin
            check("data_a", data_a, m_data[0]);
            check("rv_a",   rv_a,   m_rv);
            check("se_a",   se_a,   m_se);
            check("chg_a",  chg_a,  m_chg[0]);
            check("data_b", data_b, m_data[1]);
            check("rv_b",   rv_b,   m_rv);
            check("se_b",   se_b,   m_se);
            check("chg_b",  chg_b,  m_chg[1]);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ch(input int c, input logic [DW-1:0] v);
        io_in[c*DW +: DW] = v;
    endtask

    task automatic read_once(input logic [NCH-1:0] sel);
        ior   = 1'b1;
        chsel = sel;
        cyc(1);
        ior   = 1'b0;
        chsel = '0;
    endtask

    initial begin
        cyc(3);
        check("rst_data", data_a, 0);
        check("rst_chg",  chg_a,  0);
        check("rst_rv",   rv_a,   0);

        // Settle: ch2 step from edge 1 after release.
        reset = 1'b1;
        set_ch(2, 16'hA5A5);
        cyc(1);
        check("byp_e1_chg", chg_b, 4'b0000);
        cyc(1);
        check("byp_e2_chg", chg_b, 4'b0100);
        cyc(4);
        check("settle_e6_chg", chg_a, 4'b0000);
        cyc(1);
        check("settle_e7_chg", chg_a, 4'b0100);
        read_once(4'b0100);
        check("settle_rd_data", data_a, 16'hA5A5);
        check("settle_rd_rv",   rv_a,   1);
        check("settle_rd_chg",  chg_a,  4'b0000);

        // Illegal selects.
        ior = 1'b1; chsel = 4'b0011;
        cyc(1);
        check("ill2_se",   se_a,   1);
        check("ill2_rv",   rv_a,   0);
        check("ill2_data", data_a, 16'hA5A5);
        chsel = 4'b0000;
        cyc(1);
        check("ill0_se",   se_a,   1);
        check("ill0_data", data_a, 16'hA5A5);
        ior = 1'b0;
        cyc(1);
        check("idle_se", se_a, 0);

        // Bypass change on ch0; a 2-sample pulse is a glitch for the debounced unit.
        set_ch(0, 16'h00FF);
        cyc(1);
        check("byp0_e1", chg_b[0], 0);
        cyc(1);
        check("byp0_e2", chg_b[0], 1);
        set_ch(0, 16'h0000);
        cyc(8);
        check("short_pulse_chg0", chg_a[0], 0);
        read_once(4'b0001);

        // Glitch of 3 cycles, then a 6-cycle pulse.
        set_ch(0, 16'hFFFF);
        cyc(3);
        set_ch(0, 16'h0000);
        cyc(8);
        check("glitch3_chg0", chg_a[0], 0);
        set_ch(0, 16'hFFFF);
        cyc(6);
        set_ch(0, 16'h0000);
        cyc(1);
        check("pulse6_chg0", chg_a[0], 1);
        cyc(8);

        // Collision: read ch1 on the edge its stab goes 1 -> 2.
        set_ch(1, 16'h0001);
        cyc(8);
        read_once(4'b0010);
        check("col_pre_data", data_a, 16'h0001);
        cyc(1);
        set_ch(1, 16'h0002);
        cyc(6);
        ior = 1'b1; chsel = 4'b0010;
        cyc(1);
        check("col_data", data_a, 16'h0001);
        check("col_chg1", chg_a[1], 1);
        check("col_rv",   rv_a, 1);
        cyc(1);
        check("col2_data", data_a, 16'h0002);
        check("col2_chg1", chg_a[1], 0);
        ior = 1'b0; chsel = '0;

        // Reset mid-debounce on ch3.
        set_ch(3, 16'h1234);
        cyc(8);
        read_once(4'b1000);
        check("pre_rst_data", data_a, 16'h1234);
        set_ch(3, 16'h5678);
        cyc(5);
        reset = 1'b0;
        cyc(1);
        check("mid_rst_data", data_a, 0);
        check("mid_rst_chg",  chg_a,  0);
        check("mid_rst_se",   se_a,   0);
        reset = 1'b1;
        cyc(6);
        check("rerun_e6_chg3", chg_a[3], 0);
        cyc(1);
        check("rerun_e7_chg3", chg_a[3], 1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 299) != 0);
            ior   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 4) != 0) chsel = NCH'(1) << $urandom_range(0, NCH - 1);
            else chsel = NCH'($urandom);
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 7) == 0) begin
                    if ($urandom_range(0, 1) == 1) set_ch(c, DW'($urandom));
                    else set_ch(c, io_in[c*DW +: DW] ^ (DW'(1) << $urandom_range(0, DW - 1)));
                end
            end
            cyc(1);
        end
        reset = 1'b1;
        ior   = 1'b0;
        cyc(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
